// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with a step prescaler, parallel load and a wrap pulse.
// Digit arithmetic is a ripple chain of identical per-digit slices.

module bcd_counter4_digit (
    input  logic       up,
    input  logic       cin,
    input  logic [3:0] cur,
    output logic [3:0] nxt,
    output logic       cout
);
    logic at_edge;

    always_comb begin
        at_edge = up ? (cur == 4'd9) : (cur == 4'd0);
        cout    = cin & at_edge;
        nxt     = cur;
        if (cin) begin
            if (up) nxt = at_edge ? 4'd0 : cur + 4'd1;
            else    nxt = at_edge ? 4'd9 : cur - 4'd1;
        end
    end
endmodule

module bcd_counter4 #(
    parameter int TICK_DIV = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    output logic [3:0] s3,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       step,
    output logic       wrap
);
    localparam int NUM_DIG = 4;
    localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]               pc;
    logic [NUM_DIG-1:0][3:0]     dig;
    logic [NUM_DIG-1:0][3:0]     dig_nxt;
    logic [NUM_DIG-1:0][3:0]     dig_ld;
    logic [NUM_DIG:0]            carry;
    logic [NUM_DIG-1:0][3:0]     d_in;

    assign d_in     = {d3, d2, d1, d0};
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < NUM_DIG; i++) begin : g_dig
            bcd_counter4_digit u_dig (
                .up   (up),
                .cin  (carry[i]),
                .cur  (dig[i]),
                .nxt  (dig_nxt[i]),
                .cout (carry[i+1])
            );
            // Out-of-range load digits collapse to 0 so the count stays BCD.
            assign dig_ld[i] = (d_in[i] > 4'd9) ? 4'd0 : d_in[i];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            dig  <= '0;
            pc   <= '0;
            step <= 1'b0;
            wrap <= 1'b0;
        end else begin
            step <= 1'b0;
            wrap <= 1'b0;
            if (load) begin
                dig <= dig_ld;
                pc  <= '0;
            end else if (en) begin
                if (pc == PC_LAST) begin
                    pc   <= '0;
                    dig  <= dig_nxt;
                    step <= 1'b1;
                    wrap <= carry[NUM_DIG];
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

    assign s3 = dig[3];
    assign s2 = dig[2];
    assign s1 = dig[1];
    assign s0 = dig[0];
endmodule

// File: tb/tb_bcd_counter4.sv
// Directed bench for bcd_counter4: one instance at TICK_DIV=4, one at TICK_DIV=1.
module tb_bcd_counter4;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr, en, up, load;
    logic [3:0] d3, d2, d1, d0, s3, s2, s1, s0;
    logic       step, wrap;
    logic       clrb, enb, upb, loadb;
    logic [3:0] e3, e2, e1, e0, t3, t2, t1, t0;
    logic       stepb, wrapb;
    logic [15:0] sa, sb;

    int checks = 0;
    int failures = 0;

    assign sa = {s3, s2, s1, s0};
    assign sb = {t3, t2, t1, t0};

    bcd_counter4 #(.TICK_DIV(4)) u_a (
        .clk(clk), .clr(clr), .en(en), .up(up), .load(load),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .s3(s3), .s2(s2), .s1(s1), .s0(s0), .step(step), .wrap(wrap)
    );

    bcd_counter4 #(.TICK_DIV(1)) u_b (
        .clk(clk), .clr(clrb), .en(enb), .up(upb), .load(loadb),
        .d3(e3), .d2(e2), .d1(e1), .d0(e0),
        .s3(t3), .s2(t2), .s1(t1), .s0(t0), .step(stepb), .wrap(wrapb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [15:0] v);
        {d3, d2, d1, d0} = v;
    endtask

    initial begin
        clr = 1; en = 0; up = 1; load = 0; set_d(16'h0000);
        clrb = 1; enb = 0; upb = 1; loadb = 0; {e3, e2, e1, e0} = 16'h0000;

        // reset and idle
        tick(); tick();
        chk("rst_s", {16'h0, sa}, 32'h0);
        chk("rst_step", {31'h0, step}, 32'h0);
        chk("rst_wrap", {31'h0, wrap}, 32'h0);
        chk("rstb_s", {16'h0, sb}, 32'h0);
        clr = 0; clrb = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_s", {16'h0, sa}, 32'h0);
            chk("idle_sw", {30'h0, step, wrap}, 32'h0);
        end

        // count up 40 edges
        en = 1; up = 1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk("up_step", {31'h0, step}, (k % 4 == 0) ? 32'h1 : 32'h0);
        end
        chk("up40_s", {16'h0, sa}, 32'h0010);

        // up wrap from 9998
        en = 0; load = 1; set_d(16'h9998);
        tick();
        load = 0;
        chk("ld9998", {16'h0, sa}, 32'h9998);
        chk("ld_step", {31'h0, step}, 32'h0);
        en = 1;
        repeat (3) tick();
        chk("pre9999", {16'h0, sa}, 32'h9998);
        tick();
        chk("s9999", {16'h0, sa}, 32'h9999);
        chk("s9999_sw", {30'h0, step, wrap}, 32'h2);
        repeat (3) tick();
        chk("pre_wrap", {31'h0, wrap}, 32'h0);
        tick();
        chk("wrap_s", {16'h0, sa}, 32'h0000);
        chk("wrap_sw", {30'h0, step, wrap}, 32'h3);
        tick();
        chk("wrap_1cyc", {31'h0, wrap}, 32'h0);

        // down wrap from 0000, then invalid-digit load
        en = 0; load = 1; set_d(16'h0000);
        tick();
        load = 0; up = 0; en = 1;
        repeat (4) tick();
        chk("dn_s", {16'h0, sa}, 32'h9999);
        chk("dn_wrap", {31'h0, wrap}, 32'h1);
        en = 0; load = 1; set_d(16'h0F3A);
        tick();
        load = 0;
        chk("ld_inval", {16'h0, sa}, 32'h0030);

        // en hold keeps prescaler phase
        up = 1; en = 1;
        repeat (2) tick();
        en = 0;
        repeat (5) tick();
        chk("hold_s", {16'h0, sa}, 32'h0030);
        en = 1;
        tick();
        chk("hold_nostep", {31'h0, step}, 32'h0);
        tick();
        chk("hold_step", {31'h0, step}, 32'h1);
        chk("hold_s2", {16'h0, sa}, 32'h0031);

        // clr mid-interval restarts a full interval
        repeat (2) tick();
        clr = 1;
        tick();
        clr = 0;
        chk("clr_s", {16'h0, sa}, 32'h0000);
        repeat (3) tick();
        chk("clr_nostep", {16'h0, sa, 3'b0, step}, 32'h0);
        tick();
        chk("clr_step", {16'h0, sa}, 32'h0001);
        chk("clr_step_p", {31'h0, step}, 32'h1);

        // TICK_DIV=1 instance: step every edge across a triple carry
        loadb = 1; {e3, e2, e1, e0} = 16'h0995;
        tick();
        loadb = 0;
        chk("b_ld", {16'h0, sb}, 32'h0995);
        enb = 1; upb = 1;
        tick(); chk("b_0996", {16'h0, sb}, 32'h0996);
        tick(); chk("b_0997", {16'h0, sb}, 32'h0997);
        tick(); chk("b_0998", {16'h0, sb}, 32'h0998);
        tick(); chk("b_0999", {16'h0, sb}, 32'h0999);
        tick(); chk("b_1000", {16'h0, sb}, 32'h1000);
        chk("b_sw", {30'h0, stepb, wrapb}, 32'h2);
        clrb = 1; loadb = 1; {e3, e2, e1, e0} = 16'h1234;
        tick();
        chk("b_clr_ld", {16'h0, sb}, 32'h0000);
        chk("b_clr_sw", {30'h0, stepb, wrapb}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
